pwm_shadow_bank: RTL and testbench

- Parametrised successor to the PCA register store: N channels of B-byte PWM parameters, each with a staging copy and an atomically updated shadow copy.
- Adds a selectable commit mode: per-channel (all bytes written) or bus-STOP.
- Adds broadcast (ALL_LED) writes, a registered read-back port and per-channel commit strobes.
- Sits between the I2C register decoder and the PWM generators.

---
 rtl/pca_pkg.sv | 32 +++
 rtl/pwm_shadow_channel.sv | 67 ++++++
 rtl/pwm_shadow_bank.sv | 88 ++++++++
 tb/tb_pwm_shadow_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pca_pkg.sv
// Shared register-map constants, default byte values and the commit-mode
// encoding for the PCA-style PWM register store.
package pca_pkg;

  localparam int unsigned PCA_NUM_CH       = 16;
  localparam int unsigned PCA_BYTES_PER_CH = 4;

  // Channel 0 and broadcast register addresses (byte 0 .. byte 3).
  localparam logic [7:0] PCA_LED_0_ON_L    = 8'h06;
  localparam logic [7:0] PCA_LED_0_ON_H    = 8'h07;
  localparam logic [7:0] PCA_LED_0_OFF_L   = 8'h08;
  localparam logic [7:0] PCA_LED_0_OFF_H   = 8'h09;
  localparam logic [7:0] PCA_ALL_LED_ON_L  = 8'hFA;
  localparam logic [7:0] PCA_ALL_LED_ON_H  = 8'hFB;
  localparam logic [7:0] PCA_ALL_LED_OFF_L = 8'hFC;
  localparam logic [7:0] PCA_ALL_LED_OFF_H = 8'hFD;

  // Power-up byte values: OFF_H bit 4 set means the output is fully off.
  localparam logic [7:0] PCA_ON_L_DEFAULT  = 8'h00;
  localparam logic [7:0] PCA_ON_H_DEFAULT  = 8'h00;
  localparam logic [7:0] PCA_OFF_L_DEFAULT = 8'h00;
  localparam logic [7:0] PCA_OFF_H_DEFAULT = 8'h10;

  localparam logic [31:0] PCA_RESET_CH_VALUE = {PCA_OFF_H_DEFAULT, PCA_OFF_L_DEFAULT,
                                                PCA_ON_H_DEFAULT,  PCA_ON_L_DEFAULT};

  typedef enum logic {
    COMMIT_PER_CH  = 1'b0,  // commit as soon as every byte of a channel is written
    COMMIT_ON_STOP = 1'b1   // commit fully written channels on the bus STOP pulse
  } commit_mode_e;

endpackage

// File: rtl/pwm_shadow_channel.sv
// One channel: staging word, per-byte dirty flags, committed shadow word and
// a one-cycle commit pulse whenever the shadow loads.
module pwm_shadow_channel
  import pca_pkg::*;
#(
  parameter int unsigned             BYTES       = 4,
  parameter logic [8*BYTES-1:0]      RESET_VALUE = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BYTES-1:0]     byte_we_i,
  input  logic [7:0]           data_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  output logic [8*BYTES-1:0]   staging_o,
  output logic [8*BYTES-1:0]   shadow_o,
  output logic                 commit_o
);

  localparam int unsigned CW = 8 * BYTES;

  logic [CW-1:0]    staging_q, staging_d;
  logic [CW-1:0]    shadow_q,  shadow_d;
  logic [BYTES-1:0] dirty_q,   dirty_d;
  logic             commit_q;
  logic             commit_go;
  commit_mode_e     mode;

  assign mode      = commit_mode_e'(mode_i);
  // Decided on the registered flags only: a byte written this cycle cannot
  // complete the channel until the next edge.
  assign commit_go = (&dirty_q) && ((mode == COMMIT_PER_CH) || stop_i);

  // Next state: byte writes land in staging; a commit copies the pre-edge
  // staging word and clears every flag except bytes written this same cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
    staging_d = staging_q;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_we_i[k]) staging_d[k*8 +: 8] = data_i;
    end
    dirty_d  = (commit_go ? '0 : dirty_q) | byte_we_i;
    shadow_d = commit_go ? staging_q : shadow_q;
  end

  // State registers with synchronous reset that overrides writes and commits.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so each register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      // NOTE: the staging word is reset too, because its value is visible on read-back and in the next commit.
      staging_q <= RESET_VALUE;
      shadow_q  <= RESET_VALUE;
      dirty_q   <= '0;
      commit_q  <= 1'b0;
    end else begin
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      dirty_q   <= dirty_d;
      commit_q  <= commit_go;
    end
  end

  assign staging_o = staging_q;
  assign shadow_o  = shadow_q;
  assign commit_o  = commit_q;

endmodule

// File: rtl/pwm_shadow_bank.sv
// Bank of NUM_CH shadowed PWM channels between the I2C register decoder and
// the PWM generators: address decode, broadcast writes and registered read-back.
module pwm_shadow_bank
  import pca_pkg::*;
#(
  parameter int unsigned                  NUM_CH         = PCA_NUM_CH,
  parameter int unsigned                  BYTES_PER_CH   = PCA_BYTES_PER_CH,
  parameter logic [7:0]                   BASE_ADDR      = PCA_LED_0_ON_L,
  parameter logic [7:0]                   ALL_ADDR       = PCA_ALL_LED_ON_L,
  parameter logic [8*BYTES_PER_CH-1:0]    RESET_CH_VALUE = PCA_RESET_CH_VALUE
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               wr_en_i,
  input  logic [7:0]                         wr_addr_i,
  input  logic [7:0]                         wr_data_i,
  input  logic                               stop_i,
  input  logic                               commit_mode_i,
  input  logic [7:0]                         rd_addr_i,
  output logic [7:0]                         rd_data_o,
  output logic [NUM_CH*8*BYTES_PER_CH-1:0]   shadow_o,
  output logic [NUM_CH-1:0]                  commit_o
);

  localparam int unsigned CW = 8 * BYTES_PER_CH;

  // Addresses are widened to 9 bits so a channel range running past 8'hFF
  // cannot alias onto low addresses.
  logic [8:0] wr_addr9, rd_addr9;
  assign wr_addr9 = {1'b0, wr_addr_i};
  assign rd_addr9 = {1'b0, rd_addr_i};

  logic [NUM_CH-1:0][BYTES_PER_CH-1:0] byte_we;
  logic [NUM_CH-1:0][CW-1:0]           staging;
  logic [7:0]                          rd_data_q, rd_data_d;

  // Write decode: a byte enable fires for its own address or its broadcast slot.
  always_comb begin
    byte_we = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < BYTES_PER_CH; k++) begin
        if (wr_en_i &&
            ((wr_addr9 == 9'(int'(BASE_ADDR) + c*BYTES_PER_CH + k)) ||
             (wr_addr9 == 9'(int'(ALL_ADDR) + k)))) begin
          byte_we[c][k] = 1'b1;
        end
      end
    end
  end

  // Read mux over staging bytes; anything outside the channel range reads 0.
  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < BYTES_PER_CH; k++) begin
        if (rd_addr9 == 9'(int'(BASE_ADDR) + c*BYTES_PER_CH + k)) begin
          rd_data_d = staging[c][k*8 +: 8];
        end
      end
    end
  end

  // Registered read-back data.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_shadow_channel #(
      .BYTES       (BYTES_PER_CH),
      .RESET_VALUE (RESET_CH_VALUE)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .byte_we_i (byte_we[c]),
      .data_i    (wr_data_i),
      .stop_i    (stop_i),
      .mode_i    (commit_mode_i),
      .staging_o (staging[c]),
      .shadow_o  (shadow_o[c*CW +: CW]),
      .commit_o  (commit_o[c])
    );
  end

endmodule

// File: tb/tb_pwm_shadow_bank.sv
// Self-checking bench for pwm_shadow_bank: a hand-written vector table for the
// directed scenarios, then random traffic against a register-map model.
module tb_pwm_shadow_bank;

  localparam int NCH  = 16;
  localparam int BPC  = 4;
  localparam int BASE = 6;
  localparam int ALL  = 250;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            wr_en_i = 1'b0;
  logic [7:0]      wr_addr_i = '0;
  logic [7:0]      wr_data_i = '0;
  logic            stop_i = 1'b0;
  logic            commit_mode_i = 1'b0;
  logic [7:0]      rd_addr_i = '0;
  logic [7:0]      rd_data_o;
  logic [NCH*32-1:0] shadow_o;
  logic [NCH-1:0]  commit_o;

  pwm_shadow_bank dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .stop_i        (stop_i),
    .commit_mode_i (commit_mode_i),
    .rd_addr_i     (rd_addr_i),
    .rd_data_o     (rd_data_o),
    .shadow_o      (shadow_o),
    .commit_o      (commit_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: the register map as plain arrays -----
  logic [7:0]  stage_m [NCH][BPC];
  bit          dirty_m [NCH][BPC];
  logic [31:0] shadow_m[NCH];
  logic [15:0] commit_m;
  logic [7:0]  rd_m;

  function automatic logic [7:0] model_read(logic [7:0] addr);
    int a = int'(addr);
    if (a >= BASE && a < BASE + NCH*BPC) return stage_m[(a-BASE)/BPC][(a-BASE)%BPC];
    return 8'h00;
  endfunction

  function automatic logic [511:0] model_shadow();
    logic [511:0] s = '0;
    for (int c = 0; c < NCH; c++) s[c*32 +: 32] = shadow_m[c];
    return s;
  endfunction

  task automatic model_edge(bit rst, bit we, logic [7:0] addr, logic [7:0] data,
                            bit stop, bit mode, logic [7:0] rd);
    logic [31:0] rv = 32'h1000_0000;
    int a = int'(addr);
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        shadow_m[c] = rv;
        for (int k = 0; k < BPC; k++) begin
          stage_m[c][k] = rv[k*8 +: 8];
          dirty_m[c][k] = 0;
        end
      end
      commit_m = '0;
      rd_m     = '0;
      return;
    end
    rd_m = model_read(rd);
    for (int c = 0; c < NCH; c++) begin
      bit full = 1;
      for (int k = 0; k < BPC; k++) full &= dirty_m[c][k];
      commit_m[c] = full && (!mode || stop);
      if (commit_m[c]) begin
        for (int k = 0; k < BPC; k++) begin
          shadow_m[c][k*8 +: 8] = stage_m[c][k];
          dirty_m[c][k] = 0;
        end
      end
    end
    if (we) begin
      if (a >= BASE && a < BASE + NCH*BPC) begin
        stage_m[(a-BASE)/BPC][(a-BASE)%BPC] = data;
        dirty_m[(a-BASE)/BPC][(a-BASE)%BPC] = 1;
      end else if (a >= ALL && a < ALL + BPC) begin
        for (int c = 0; c < NCH; c++) begin
          stage_m[c][a-ALL] = data;
          dirty_m[c][a-ALL] = 1;
        end
      end
    end
  endtask

  // One clock: drive inputs away from the edge, update the model at the edge,
  // compare every output 1 time unit later.
  task automatic step(bit rst, bit we, logic [7:0] addr, logic [7:0] data,
                      bit stop, bit mode, logic [7:0] rd);
    rst_i = rst; wr_en_i = we; wr_addr_i = addr; wr_data_i = data;
    stop_i = stop; commit_mode_i = mode; rd_addr_i = rd;
    @(posedge clk_i);
    model_edge(rst, we, addr, data, stop, mode, rd);
    #1;
    check("model_shadow", shadow_o, model_shadow());
    check("model_commit", commit_o, commit_m);
    check("model_rd_data", rd_data_o, rd_m);
  endtask

  // ---------------- directed table -----------------------------------------
  typedef struct {
    bit          rst;
    bit          we;
    logic [7:0]  addr;
    logic [7:0]  data;
    bit          stop;
    bit          mode;
    logic [7:0]  rd;
    int          rep;
    logic [15:0] exp_commit;
    logic [7:0]  exp_rd;
    int          ch;
    logic [31:0] exp_sh;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit we, logic [7:0] addr, logic [7:0] data,
                             bit stop, bit mode, logic [7:0] rd, int rep,
                             logic [15:0] ec, logic [7:0] erd, int ch, logic [31:0] esh);
    vec_t r;
    r.rst = rst; r.we = we; r.addr = addr; r.data = data; r.stop = stop;
    r.mode = mode; r.rd = rd; r.rep = rep; r.exp_commit = ec; r.exp_rd = erd;
    r.ch = ch; r.exp_sh = esh;
    return r;
  endfunction

  initial begin
    // reset and read-back of reset staging
    tbl.push_back(v(1,0,8'h00,8'h00,0,0,8'h09,1,16'h0000,8'h00, 0,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'h09,1,16'h0000,8'h10, 0,32'h1000_0000));
    // mode 0: channel 0 fill, commit one edge after the last byte
    tbl.push_back(v(0,1,8'h06,8'h01,0,0,8'h06,1,16'h0000,8'h00, 0,32'h1000_0000));
    tbl.push_back(v(0,1,8'h07,8'h02,0,0,8'h06,1,16'h0000,8'h01, 0,32'h1000_0000));
    tbl.push_back(v(0,1,8'h08,8'h03,0,0,8'hFF,1,16'h0000,8'h00, 0,32'h1000_0000));
    tbl.push_back(v(0,1,8'h09,8'h04,0,0,8'hFF,1,16'h0000,8'h00, 0,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'hFF,1,16'h0001,8'h00, 0,32'h0403_0201));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h1000_0000));
    // mode 0 partial channel 1, long idle, then completion
    tbl.push_back(v(0,1,8'h0A,8'h11,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h1000_0000));
    tbl.push_back(v(0,1,8'h0B,8'h12,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h1000_0000));
    tbl.push_back(v(0,1,8'h0C,8'h13,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'hFF,10,16'h0000,8'h00,1,32'h1000_0000));
    tbl.push_back(v(0,1,8'h0D,8'hAA,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'hFF,1,16'h0002,8'h00, 1,32'hAA13_1211));
    // mode 1: full ch2 and half ch3, STOP commits ch2 only
    tbl.push_back(v(0,1,8'h0E,8'h21,0,1,8'hFF,1,16'h0000,8'h00, 2,32'h1000_0000));
    tbl.push_back(v(0,1,8'h0F,8'h22,0,1,8'hFF,1,16'h0000,8'h00, 2,32'h1000_0000));
    tbl.push_back(v(0,1,8'h10,8'h23,0,1,8'hFF,1,16'h0000,8'h00, 2,32'h1000_0000));
    tbl.push_back(v(0,1,8'h11,8'h24,0,1,8'hFF,1,16'h0000,8'h00, 2,32'h1000_0000));
    tbl.push_back(v(0,1,8'h12,8'h31,0,1,8'hFF,1,16'h0000,8'h00, 2,32'h1000_0000));
    tbl.push_back(v(0,1,8'h13,8'h32,0,1,8'hFF,1,16'h0000,8'h00, 2,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,1,8'hFF,3,16'h0000,8'h00, 2,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,1,1,8'hFF,1,16'h0004,8'h00, 2,32'h2423_2221));
    tbl.push_back(v(0,0,8'h00,8'h00,0,1,8'hFF,1,16'h0000,8'h00, 3,32'h1000_0000));
    tbl.push_back(v(0,1,8'h14,8'h33,0,1,8'hFF,1,16'h0000,8'h00, 3,32'h1000_0000));
    tbl.push_back(v(0,1,8'h15,8'h34,0,1,8'hFF,1,16'h0000,8'h00, 3,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,1,8'hFF,2,16'h0000,8'h00, 3,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,1,1,8'hFF,1,16'h0008,8'h00, 3,32'h3433_3231));
    // full channel 4 held in mode 1, released by switching to mode 0
    tbl.push_back(v(0,1,8'h16,8'h41,0,1,8'hFF,1,16'h0000,8'h00, 4,32'h1000_0000));
    tbl.push_back(v(0,1,8'h17,8'h42,0,1,8'hFF,1,16'h0000,8'h00, 4,32'h1000_0000));
    tbl.push_back(v(0,1,8'h18,8'h43,0,1,8'hFF,1,16'h0000,8'h00, 4,32'h1000_0000));
    tbl.push_back(v(0,1,8'h19,8'h44,0,1,8'hFF,1,16'h0000,8'h00, 4,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,1,8'hFF,1,16'h0000,8'h00, 4,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'hFF,1,16'h0010,8'h00, 4,32'h4443_4241));
    // broadcast fill commits every channel on the same edge
    tbl.push_back(v(0,1,8'hFA,8'h11,0,0,8'hFF,1,16'h0000,8'h00,15,32'h1000_0000));
    tbl.push_back(v(0,1,8'hFB,8'h22,0,0,8'hFF,1,16'h0000,8'h00,15,32'h1000_0000));
    tbl.push_back(v(0,1,8'hFC,8'h33,0,0,8'hFF,1,16'h0000,8'h00,15,32'h1000_0000));
    tbl.push_back(v(0,1,8'hFD,8'h44,0,0,8'hFF,1,16'h0000,8'h00,15,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'h45,1,16'hFFFF,8'h44,15,32'h4433_2211));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'hFF,1,16'h0000,8'h00, 0,32'h4433_2211));
    // write to byte 0 on the commit edge of a full channel 0
    tbl.push_back(v(0,1,8'h06,8'hA1,0,0,8'hFF,1,16'h0000,8'h00, 0,32'h4433_2211));
    tbl.push_back(v(0,1,8'h07,8'hA2,0,0,8'hFF,1,16'h0000,8'h00, 0,32'h4433_2211));
    tbl.push_back(v(0,1,8'h08,8'hA3,0,0,8'hFF,1,16'h0000,8'h00, 0,32'h4433_2211));
    tbl.push_back(v(0,1,8'h09,8'hA4,0,0,8'hFF,1,16'h0000,8'h00, 0,32'h4433_2211));
    tbl.push_back(v(0,1,8'h06,8'h55,0,0,8'hFF,1,16'h0001,8'h00, 0,32'hA4A3_A2A1));
    tbl.push_back(v(0,1,8'h07,8'hB2,0,0,8'hFF,1,16'h0000,8'h00, 0,32'hA4A3_A2A1));
    tbl.push_back(v(0,1,8'h08,8'hB3,0,0,8'hFF,1,16'h0000,8'h00, 0,32'hA4A3_A2A1));
    tbl.push_back(v(0,1,8'h09,8'hB4,0,0,8'hFF,1,16'h0000,8'h00, 0,32'hA4A3_A2A1));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'hFF,1,16'h0001,8'h00, 0,32'hB4B3_B255));
    // reset mid-burst, then a lone byte must not commit
    tbl.push_back(v(0,1,8'h0A,8'h77,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h4433_2211));
    tbl.push_back(v(0,1,8'h0B,8'h78,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h4433_2211));
    tbl.push_back(v(1,1,8'h0C,8'h79,1,0,8'h0C,1,16'h0000,8'h00, 1,32'h1000_0000));
    tbl.push_back(v(0,1,8'h0D,8'h99,0,0,8'hFF,1,16'h0000,8'h00, 1,32'h1000_0000));
    tbl.push_back(v(0,0,8'h00,8'h00,0,0,8'h0D,3,16'h0000,8'h99, 1,32'h1000_0000));

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        step(tbl[i].rst, tbl[i].we, tbl[i].addr, tbl[i].data,
             tbl[i].stop, tbl[i].mode, tbl[i].rd);
        check($sformatf("row%0d_commit", i), commit_o, tbl[i].exp_commit);
        check($sformatf("row%0d_rd_data", i), rd_data_o, tbl[i].exp_rd);
        check($sformatf("row%0d_shadow_ch%0d", i, tbl[i].ch),
              shadow_o[tbl[i].ch*32 +: 32], tbl[i].exp_sh);
      end
    end

    // ---------------- random traffic against the model ---------------------
    begin
      bit mode = 0;
      for (int i = 0; i < 3000; i++) begin
        bit         rst  = ($urandom_range(0, 199) == 0);
        bit         we   = ($urandom_range(0, 3) != 0);
        bit         stop = ($urandom_range(0, 7) == 0);
        logic [7:0] addr, rd;
        int         sel  = $urandom_range(0, 9);
        if ($urandom_range(0, 49) == 0) mode = ~mode;
        if (sel < 7)       addr = 8'(BASE + $urandom_range(0, NCH*BPC-1));
        else if (sel == 7) addr = 8'(ALL + $urandom_range(0, 5));
        else if (sel == 8) addr = 8'($urandom_range(0, 255));
        else               addr = ($urandom_range(0, 1) != 0) ? 8'h46 : 8'h05;
        rd = ($urandom_range(0, 3) != 0) ? 8'(BASE + $urandom_range(0, NCH*BPC-1))
                                         : 8'($urandom_range(0, 255));
        step(rst, we, addr, 8'($urandom_range(0, 255)), stop, mode, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
